legv8_ctrl_seq: RTL

Control sequencer that sits directly upstream of the register-file/ALU datapath. Accepts 32-bit LEGv8 arithmetic/logic/move instructions over a valid/ready handshake, decodes them, and drives the datapath control word (DA, SA, SB, W, K, BS, FS) from registers. Single-step ops take one datapath cycle. MOVK is sequenced as two datapath cycles (mask, then merge). Optionally latches the datapath `status` into NZCV flags for flag-setting opcodes.

---
 rtl/legv8_ctrl_seq_if.sv | 9 +
 rtl/legv8_ctrl_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/legv8_ctrl_seq_if.sv
// Instruction handshake between the issuing front end and the LEGv8 control sequencer.
interface legv8_ctrl_seq_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (output instr, output instr_valid, input instr_ready);
    modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/legv8_ctrl_seq.sv
// LEGv8 control sequencer: decodes arithmetic/logic/move instructions into a registered datapath control word.
// Optional NZCV flag latch enabled by defining CTRL_FLAGS_EN.
module legv8_ctrl_seq (
    input  logic                    clock,
    input  logic                    reset,
    legv8_ctrl_seq_if.slave         bus,
    input  logic [3:0]              status,
    output logic [4:0]              DA,
    output logic [4:0]              SA,
    output logic [4:0]              SB,
    output logic                    W,
    output logic [63:0]             K,
    output logic                    BS,
    output logic [4:0]              FS,
    output logic [3:0]              flags,
    output logic                    illegal
);
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01011;
    localparam logic [4:0] FS_EOR = 5'b01100;

    typedef enum logic [1:0] {IDLE, EXEC, EXEC2A, EXEC2B} state_t;

    state_t      state, state_n;
    logic        ready_q, accept;
    logic [4:0]  rd, rn, rm;
    logic [63:0] imm_sh, movk_mask, k2, k2_n;
    logic        d_legal, d_movk, d_rtype;
    logic [4:0]  d_fs, d_sa;
    logic [63:0] d_k;
    logic [4:0]  da_n, sa_n, sb_n, fs_n;
    logic [63:0] k_n;
    logic        bs_n, w_n, ill_n;
`ifdef CTRL_FLAGS_EN
    logic        d_setf, setf_q, setf_n;
`endif

    assign rd        = bus.instr[4:0];
    assign rn        = bus.instr[9:5];
    assign rm        = bus.instr[20:16];
    assign imm_sh    = {48'b0, bus.instr[20:5]} << {bus.instr[22:21], 4'b0000};
    assign movk_mask = ~(64'hFFFF << {bus.instr[22:21], 4'b0000});
    assign accept    = bus.instr_valid && ready_q;
    assign bus.instr_ready = ready_q;

    always_comb begin
        d_legal = 1'b0;
        d_movk  = 1'b0;
        d_rtype = 1'b0;
        d_fs    = '0;
        d_sa    = rn;
        d_k     = '0;
`ifdef CTRL_FLAGS_EN
        d_setf  = 1'b0;
`endif
        case (bus.instr[31:21])
            11'b10001011000: begin d_legal = 1'b1; d_rtype = 1'b1; d_fs = FS_ADD; end
            11'b11001011000: begin d_legal = 1'b1; d_rtype = 1'b1; d_fs = FS_SUB; end
            11'b10001010000: begin d_legal = 1'b1; d_rtype = 1'b1; d_fs = FS_AND; end
            11'b10101010000: begin d_legal = 1'b1; d_rtype = 1'b1; d_fs = FS_ORR; end
            11'b11001010000: begin d_legal = 1'b1; d_rtype = 1'b1; d_fs = FS_EOR; end
`ifdef CTRL_FLAGS_EN
            11'b10101011000: begin d_legal = 1'b1; d_rtype = 1'b1; d_fs = FS_ADD; d_setf = 1'b1; end
            11'b11101011000: begin d_legal = 1'b1; d_rtype = 1'b1; d_fs = FS_SUB; d_setf = 1'b1; end
`endif
            default: ;
        endcase
        case (bus.instr[31:22])
            10'b1001000100: begin d_legal = 1'b1; d_fs = FS_ADD; d_k = {52'b0, bus.instr[21:10]}; end
            10'b1101000100: begin d_legal = 1'b1; d_fs = FS_SUB; d_k = {52'b0, bus.instr[21:10]}; end
            10'b1001001000: begin d_legal = 1'b1; d_fs = FS_AND; d_k = {52'b0, bus.instr[21:10]}; end
            10'b1011001000: begin d_legal = 1'b1; d_fs = FS_ORR; d_k = {52'b0, bus.instr[21:10]}; end
            10'b1101001000: begin d_legal = 1'b1; d_fs = FS_EOR; d_k = {52'b0, bus.instr[21:10]}; end
`ifdef CTRL_FLAGS_EN
            10'b1011000100: begin d_legal = 1'b1; d_fs = FS_ADD; d_k = {52'b0, bus.instr[21:10]}; d_setf = 1'b1; end
            10'b1111000100: begin d_legal = 1'b1; d_fs = FS_SUB; d_k = {52'b0, bus.instr[21:10]}; d_setf = 1'b1; end
`endif
            default: ;
        endcase
        case (bus.instr[31:23])
            9'b110100101: begin d_legal = 1'b1; d_sa = 5'd31; d_fs = FS_ORR; d_k = imm_sh; end
            9'b111100101: begin d_legal = 1'b1; d_movk = 1'b1; d_sa = rd; d_fs = FS_AND; d_k = movk_mask; end
            default: ;
        endcase
    end

    // MOVK step 2 reuses the registered DA/SA and the merge constant captured at accept.
    always_comb begin
        state_n = state;
        da_n    = DA;
        sa_n    = SA;
        sb_n    = SB;
        k_n     = K;
        bs_n    = BS;
        fs_n    = FS;
        w_n     = 1'b0;
        ill_n   = illegal;
        k2_n    = k2;
`ifdef CTRL_FLAGS_EN
        setf_n  = 1'b0;
`endif
        if (state == EXEC2A) begin
            state_n = EXEC2B;
            k_n     = k2;
            fs_n    = FS_ORR;
            w_n     = (DA != 5'd31);
        end else if (accept) begin
            if (!d_legal) begin
                ill_n   = 1'b1;
                state_n = IDLE;
            end else begin
                da_n    = rd;
                sa_n    = d_sa;
                fs_n    = d_fs;
                w_n     = (rd != 5'd31);
                k2_n    = imm_sh;
                state_n = d_movk ? EXEC2A : EXEC;
                if (d_rtype) begin
                    sb_n = rm;
                    bs_n = 1'b0;
                end else begin
                    k_n  = d_k;
                    bs_n = 1'b1;
                end
`ifdef CTRL_FLAGS_EN
                setf_n = d_setf;
`endif
            end
        end else begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b1;
            DA      <= '0;
            SA      <= '0;
            SB      <= '0;
            K       <= '0;
            BS      <= 1'b0;
            FS      <= '0;
            W       <= 1'b0;
            illegal <= 1'b0;
            k2      <= '0;
        end else begin
            ready_q <= (state_n != EXEC2A);
            DA      <= da_n;
            SA      <= sa_n;
            SB      <= sb_n;
            K       <= k_n;
            BS      <= bs_n;
            FS      <= fs_n;
            W       <= w_n;
            illegal <= ill_n;
            k2      <= k2_n;
        end
    end

`ifdef CTRL_FLAGS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            setf_q <= 1'b0;
            flags  <= '0;
        end else begin
            setf_q <= setf_n;
            if (setf_q) flags <= status;
        end
    end
`else
    logic unused_status;
    assign unused_status = ^status;
    assign flags = '0;
`endif
endmodule
